// File: rtl/wgt_rf_pkg.sv
// Shared types and helpers for the weight register-file bank.
// Holds the FSM state encoding, configuration clamping and lane-mask generation.
package wgt_rf_pkg;

    // Widest lane count the mask helper supports. Callers truncate the result to CHANNELS.
    localparam int MAX_CHANNELS = 64;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PRIME,
        STREAM
    } state_t;

    // A zero or out-of-range request falls back to the full size.
    function automatic int unsigned clamp_cfg(input int unsigned val, input int unsigned max_val);
        return (val == 0 || val > max_val) ? max_val : val;
    endfunction

    function automatic logic [MAX_CHANNELS-1:0] lane_mask(input int unsigned active);
        logic [MAX_CHANNELS-1:0] mask;
        mask = '0;
        for (int unsigned i = 0; i < MAX_CHANNELS; i++) begin
            mask[i] = (i < active);
        end
        return mask;
    endfunction

endpackage

// File: rtl/wgt_rf_lane.sv
// One filter lane of the weight bank: a DEPTH-entry weight store with a registered
// read port. Write and read pointers are shared across all lanes by the bank.
module wgt_rf_lane #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 27,
    parameter int PTR_W      = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [PTR_W-1:0]      wr_ptr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [PTR_W-1:0]      rd_ptr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: the storage array is deliberately left without a reset so it maps onto
    // plain RAM/flop arrays; every entry is written before it is ever read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_ptr];
        end
    end

endmodule

// File: rtl/wgt_rf_bank.sv
// Weight register-file bank: loads up to DEPTH weight vectors and replays them a
// programmable number of passes. Define WGT_RF_ZERO_PAD_EN to zero inactive lanes on write.
module wgt_rf_bank
    import wgt_rf_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 27,
    parameter int CHANNELS   = 16,
    parameter int PASS_W     = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           clear,
    input  logic [$clog2(DEPTH+1)-1:0]     depth_cfg,
    input  logic [$clog2(CHANNELS+1)-1:0]  active_ch,
    input  logic [PASS_W-1:0]              pass_cfg,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [CHANNELS*DATA_WIDTH-1:0] out_data,
    output logic                           busy,
    output logic                           done
);

    localparam int DEPTH_W = $clog2(DEPTH + 1);
    localparam int CH_W    = $clog2(CHANNELS + 1);
    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t              state, state_nxt;
    logic [PTR_W-1:0]    wr_ptr, rd_ptr, rd_nxt, rd_addr, depth_last;
    logic [PASS_W-1:0]   pass_cnt, pass_cnt_inc, pass_r;
    logic [DEPTH_W-1:0]  depth_r;
    logic [CH_W-1:0]     active_r;
    logic [CHANNELS-1:0] lane_en;
    logic                start_fire, load_fire, prime_fire, out_fire, wrap, final_beat;

    assign depth_last   = PTR_W'(depth_r - 1'b1);
    assign pass_cnt_inc = pass_cnt + 1'b1;
    assign busy         = (state != IDLE);
    // Masking in_ready with clear keeps the stream contract honest during an abort.
    assign in_ready     = (state == LOAD) && !clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can leave a
    // signal unassigned and infer a latch; blocking '=' is correct in combinational code.
    always_comb begin
        state_nxt  = state;
        start_fire = 1'b0;
        load_fire  = 1'b0;
        prime_fire = 1'b0;
        out_fire   = 1'b0;
        wrap       = 1'b0;
        final_beat = 1'b0;
        rd_nxt     = (rd_ptr == depth_last) ? '0 : rd_ptr + 1'b1;
        if (clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        start_fire = 1'b1;
                        state_nxt  = LOAD;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        load_fire = 1'b1;
                        if (wr_ptr == depth_last) begin
                            state_nxt = PRIME;
                        end
                    end
                end
                PRIME: begin
                    prime_fire = 1'b1;
                    state_nxt  = STREAM;
                end
                STREAM: begin
                    if (out_valid && out_ready) begin
                        out_fire   = 1'b1;
                        wrap       = (rd_ptr == depth_last);
                        final_beat = wrap && (pass_r != '0) && (pass_cnt_inc == pass_r);
                        if (final_beat) begin
                            state_nxt = IDLE;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking '<=' so all registers update from the
    // same pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            pass_cnt  <= '0;
            depth_r   <= DEPTH_W'(DEPTH);
            active_r  <= CH_W'(CHANNELS);
            pass_r    <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (clear) begin
                out_valid <= 1'b0;
            end else begin
                if (start_fire) begin
                    depth_r  <= DEPTH_W'(clamp_cfg(32'(depth_cfg), DEPTH));
                    active_r <= CH_W'(clamp_cfg(32'(active_ch), CHANNELS));
                    pass_r   <= pass_cfg;
                    wr_ptr   <= '0;
                    rd_ptr   <= '0;
                    pass_cnt <= '0;
                end
                if (load_fire) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (prime_fire) begin
                    out_valid <= 1'b1;
                end
                if (out_fire) begin
                    rd_ptr <= rd_nxt;
                    if (wrap) begin
                        pass_cnt <= pass_cnt_inc;
                    end
                    if (final_beat) begin
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                    end
                end
            end
        end
    end

    // PRIME fetches entry 0; each accepted replay beat prefetches the next entry.
    assign rd_addr = prime_fire ? '0 : rd_nxt;

`ifdef WGT_RF_ZERO_PAD_EN
    assign lane_en = CHANNELS'(lane_mask(32'(active_r)));
`else
    // The feeder already zero-pads, so every lane is stored; active_r stays latched
    // only to keep one configuration path for both builds.
    assign lane_en = {CHANNELS{1'b1}} | CHANNELS'(lane_mask(32'(active_r)));
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        wgt_rf_lane #(
            .DATA_WIDTH(DATA_WIDTH),
            .DEPTH     (DEPTH),
            .PTR_W     (PTR_W)
        ) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .we     (load_fire),
            .wr_ptr (wr_ptr),
            .wr_data(in_data[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{lane_en[i]}}),
            .rd_en  (prime_fire || out_fire),
            .rd_ptr (rd_addr),
            .rd_data(out_data[i*DATA_WIDTH +: DATA_WIDTH])
        );
    end

endmodule
